// File: rtl/fft_stream_buffers.sv
// fft_stream_buffers
// Buffering and sequencing shell around the 64-point FFT core.
// Input side: snapshots a parallel 64-sample frame, streams it into the core
// one sample per cycle (fft_load), then pulses fft_start. One FFT runs per
// cs-low transaction.
// Output side: on a rising fft_done, reads back 64 complex results, turns
// each into a saturated |re|+|im| magnitude and assembles a 1024-bit frame.
//
// Ports:
//   clk            - clock, all state changes on the rising edge
//   reset          - asynchronous active-low reset
//   cs             - SPI chip select, active-low (frame available)
//   fft_in1024     - input frame, sample k at [1023-16k -: 16]
//   fft_processing - core busy flag
//   fft_done       - core result-streaming flag
//   fft_out32      - core read data {re, im}, valid one cycle after fft_adr
//   fft_load       - core load strobe
//   fft_start      - one-cycle core start pulse
//   fft_in32       - core write data {sample, 16'h0000}
//   fft_adr        - core address (load index while loading, else read index)
//   fft_out1024    - magnitude frame, bin k at [1023-16k -: 16]
//   buf_ready      - magnitude frame complete and stable
//   buf_empty      - output side not capturing
module fft_stream_buffers (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs,
  input  logic [1023:0] fft_in1024,
  input  logic          fft_processing,
  input  logic          fft_done,
  input  logic [31:0]   fft_out32,
  output logic          fft_load,
  output logic          fft_start,
  output logic [31:0]   fft_in32,
  output logic [5:0]    fft_adr,
  output logic [1023:0] fft_out1024,
  output logic          buf_ready,
  output logic          buf_empty
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    START   = 3'd2,
    WAIT    = 3'd3,
    RELEASE = 3'd4
  } in_state_t;

  typedef enum logic {
    OIDLE   = 1'b0,
    CAPTURE = 1'b1
  } out_state_t;

  in_state_t     in_state_r, in_state_s;
  out_state_t    out_state_r, out_state_s;
  logic [1023:0] snap_r;       // shift register: top 16 bits = next sample to send
  logic [5:0]    in_idx_r;
  logic [6:0]    cap_cnt_r;    // 0..64; bin cap_cnt-1 is written while cap_cnt>0
  logic          done_d_r;
  logic          load_start_s;
  logic          done_rise_s;
  logic [5:0]    wr_idx_s;
  logic [9:0]    bin_base_s;

  // |re|+|im| of a signed {re, im} word, saturated to 16 bits
  function automatic logic [15:0] mag16(input logic [31:0] d);
    logic [16:0] re_abs;
    logic [16:0] im_abs;
    logic [16:0] sum;
    re_abs = d[31] ? (17'd0 - {d[31], d[31:16]}) : {1'b0, d[31:16]};
    im_abs = d[15] ? (17'd0 - {d[15], d[15:0]})  : {1'b0, d[15:0]};
    sum    = re_abs + im_abs;
    mag16  = sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  assign load_start_s = (in_state_r == IDLE) && !cs && !fft_processing && buf_empty;
  assign done_rise_s  = fft_done && !done_d_r;
  assign wr_idx_s     = cap_cnt_r[5:0] - 6'd1;
  assign bin_base_s   = 10'd1023 - {wr_idx_s, 4'h0};
  assign fft_adr      = fft_load ? in_idx_r : cap_cnt_r[5:0];

  // Input sequencer next-state logic
  always_comb begin
    in_state_s = in_state_r;
    case (in_state_r)
      IDLE:    if (load_start_s) in_state_s = LOAD; else in_state_s = IDLE;
      LOAD:    if (in_idx_r == 6'd63) in_state_s = START; else in_state_s = LOAD;
      START:   in_state_s = WAIT;
      WAIT:    if (buf_ready) in_state_s = RELEASE; else in_state_s = WAIT;
      RELEASE: if (cs) in_state_s = IDLE; else in_state_s = RELEASE;
      default: in_state_s = IDLE;
    endcase
  end

  // Input sequencer state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) in_state_r <= IDLE;
    else        in_state_r <= in_state_s;
  end

  // Input datapath: frame snapshot, sample streaming and core strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_r    <= {1024{1'b0}};
      in_idx_r  <= 6'd0;
      fft_load  <= 1'b0;
      fft_start <= 1'b0;
      fft_in32  <= 32'h0000_0000;
    end else begin
      fft_load  <= (in_state_s == LOAD);
      fft_start <= (in_state_s == START);
      if (load_start_s) begin
        // sample 0 goes out straight away; the rest wait in the shifter
        snap_r   <= {fft_in1024[1007:0], 16'h0000};
        in_idx_r <= 6'd0;
        fft_in32 <= {fft_in1024[1023:1008], 16'h0000};
      end else if ((in_state_r == LOAD) && (in_idx_r != 6'd63)) begin
        snap_r   <= {snap_r[1007:0], 16'h0000};
        in_idx_r <= in_idx_r + 6'd1;
        fft_in32 <= {snap_r[1023:1008], 16'h0000};
      end else begin
        fft_in32 <= 32'h0000_0000;
      end
    end
  end

  // Output capture next-state logic
  always_comb begin
    out_state_s = out_state_r;
    case (out_state_r)
      OIDLE:   if (done_rise_s) out_state_s = CAPTURE; else out_state_s = OIDLE;
      CAPTURE: if (cap_cnt_r == 7'd64) out_state_s = OIDLE; else out_state_s = CAPTURE;
      default: out_state_s = OIDLE;
    endcase
  end

  // Output capture state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out_state_r <= OIDLE;
    else        out_state_r <= out_state_s;
  end

  // Output datapath: read index, magnitude frame and status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_cnt_r   <= 7'd0;
      done_d_r    <= 1'b0;
      fft_out1024 <= {1024{1'b0}};
      buf_ready   <= 1'b0;
      buf_empty   <= 1'b1;
    end else begin
      done_d_r <= fft_done;
      case (out_state_r)
        OIDLE: begin
          if (done_rise_s) begin
            cap_cnt_r <= 7'd0;
            buf_empty <= 1'b0;
            buf_ready <= 1'b0;
          end else if (load_start_s) begin
            // a new input frame invalidates the previous result
            buf_ready <= 1'b0;
          end
        end
        CAPTURE: begin
          // read data lags the address by one cycle, so write the previous bin
          if (cap_cnt_r != 7'd0) begin
            fft_out1024[bin_base_s -: 16] <= mag16(fft_out32);
          end
          if (cap_cnt_r == 7'd64) begin
            buf_ready <= 1'b1;
            buf_empty <= 1'b1;
          end else begin
            cap_cnt_r <= cap_cnt_r + 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_stream_buffers.sv
// Self-checking bench for fft_stream_buffers: directed sequence with
// randomized frames and core results, checked against a behavioural model.
module tb_fft_stream_buffers;

  logic          clk;
  logic          reset;
  logic          cs;
  logic [1023:0] fft_in1024;
  logic          fft_processing;
  logic          fft_done;
  logic [31:0]   fft_out32;
  logic          fft_load;
  logic          fft_start;
  logic [31:0]   fft_in32;
  logic [5:0]    fft_adr;
  logic [1023:0] fft_out1024;
  logic          buf_ready;
  logic          buf_empty;

  int n_checks;
  int n_errors;

  logic [15:0]   frame [64];   // samples presented to the DUT
  logic [31:0]   resp  [64];   // core model result memory
  logic [1023:0] exp_frame;    // expected magnitude frame

  fft_stream_buffers dut (
    .clk           (clk),
    .reset         (reset),
    .cs            (cs),
    .fft_in1024    (fft_in1024),
    .fft_processing(fft_processing),
    .fft_done      (fft_done),
    .fft_out32     (fft_out32),
    .fft_load      (fft_load),
    .fft_start     (fft_start),
    .fft_in32      (fft_in32),
    .fft_adr       (fft_adr),
    .fft_out1024   (fft_out1024),
    .buf_ready     (buf_ready),
    .buf_empty     (buf_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core read port: data appears one cycle after the address
  always @(posedge clk) fft_out32 <= resp[fft_adr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input string tag, input logic [1023:0] expf);
    for (int k = 0; k < 64; k++)
      check($sformatf("%s[%0d]", tag, k), {16'h0000, fft_out1024[1023-16*k -: 16]},
            {16'h0000, expf[1023-16*k -: 16]});
  endtask

  function automatic logic [15:0] exp_mag(input logic [31:0] d);
    int re;
    int im;
    int m;
    re = $signed(d[31:16]);
    im = $signed(d[15:0]);
    m  = (re < 0 ? -re : re) + (im < 0 ? -im : im);
    if (m > 65535) m = 65535;
    return 16'(m);
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_load"},  {31'd0, fft_load},  32'd0);
    check({tag, "_start"}, {31'd0, fft_start}, 32'd0);
    check({tag, "_in32"},  fft_in32,           32'd0);
    check({tag, "_adr"},   {26'd0, fft_adr},   32'd0);
    check({tag, "_ready"}, {31'd0, buf_ready}, 32'd0);
    check({tag, "_empty"}, {31'd0, buf_empty}, 32'd1);
    check_frame({tag, "_out"}, {1024{1'b0}});
  endtask

  // Present frame[], let the DUT load it, check the 64-cycle stream and start
  // pulse. corrupt_at: cycle at which the SPI frame is overwritten.
  // reset_at: cycle at which reset is asserted (then the task returns).
  task automatic do_load(input int corrupt_at, input int reset_at);
    for (int k = 0; k < 64; k++) fft_in1024[1023-16*k -: 16] = frame[k];
    cs = 1'b0;
    fft_processing = 1'b0;
    step();
    for (int k = 0; k < 64; k++) begin
      check($sformatf("ld_load[%0d]", k), {31'd0, fft_load}, 32'd1);
      check($sformatf("ld_start[%0d]", k), {31'd0, fft_start}, 32'd0);
      check($sformatf("ld_adr[%0d]", k), {26'd0, fft_adr}, k);
      check($sformatf("ld_in32[%0d]", k), fft_in32, {frame[k], 16'h0000});
      if (k == 0) check("ld_ready_clr", {31'd0, buf_ready}, 32'd0);
      if (k == corrupt_at) fft_in1024 = {1024{1'b1}};
      if (k == reset_at) begin
        #2;
        reset = 1'b0;
        #1;
        check_reset_state("rst_mid");
        return;
      end
      step();
    end
    check("st_load", {31'd0, fft_load}, 32'd0);
    check("st_start", {31'd0, fft_start}, 32'd1);
    step();
    check("st_start_end", {31'd0, fft_start}, 32'd0);
    check("st_load_end", {31'd0, fft_load}, 32'd0);
  endtask

  // Raise fft_done and check the 65-cycle capture and the resulting frame
  task automatic do_capture();
    for (int k = 0; k < 64; k++) exp_frame[1023-16*k -: 16] = exp_mag(resp[k]);
    fft_done = 1'b1;
    step();
    check("cap_empty0", {31'd0, buf_empty}, 32'd0);
    check("cap_ready0", {31'd0, buf_ready}, 32'd0);
    for (int i = 1; i <= 64; i++) begin
      if (i == 5) fft_done = 1'b0;   // falling mid-capture must not abort
      step();
      check($sformatf("cap_empty[%0d]", i), {31'd0, buf_empty}, 32'd0);
      check($sformatf("cap_ready[%0d]", i), {31'd0, buf_ready}, 32'd0);
    end
    step();
    check("cap_ready_end", {31'd0, buf_ready}, 32'd1);
    check("cap_empty_end", {31'd0, buf_empty}, 32'd1);
    check_frame("cap_bin", exp_frame);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    cs = 1'b1;
    fft_processing = 1'b0;
    fft_done = 1'b0;
    fft_in1024 = {1024{1'b0}};
    for (int k = 0; k < 64; k++) resp[k] = 32'd0;

    // Reset state
    step();
    step();
    check_reset_state("rst");
    reset = 1'b1;
    step();
    check("idle_load", {31'd0, fft_load}, 32'd0);

    // Round 1: ramp frame, SPI frame overwritten mid-load
    for (int k = 0; k < 64; k++) frame[k] = 16'(k * 16'h0101);
    do_load(10, -1);
    for (int k = 0; k < 64; k++) resp[k] = {16'(k), 16'(-k)};
    do_capture();

    // cs held low after the result: no new load
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("cs_hold_load[%0d]", i), {31'd0, fft_load}, 32'd0);
      check($sformatf("cs_hold_ready[%0d]", i), {31'd0, buf_ready}, 32'd1);
    end
    cs = 1'b1;
    step();
    check("cs_high_load", {31'd0, fft_load}, 32'd0);
    check("cs_high_ready", {31'd0, buf_ready}, 32'd1);

    // Round 2: random frame, random results with saturation corner cases
    for (int k = 0; k < 64; k++) frame[k] = 16'($urandom);
    do_load(-1, -1);
    check_frame("held", exp_frame);
    for (int k = 0; k < 64; k++) resp[k] = $urandom;
    resp[0] = {16'h8000, 16'h8000};
    resp[1] = {16'h7FFF, 16'h0001};
    resp[2] = {16'h8000, 16'h0000};
    resp[63] = {16'h0000, 16'h8001};
    do_capture();
    check("sat_8000_8000", {16'h0000, fft_out1024[1023 -: 16]}, 32'h0000FFFF);
    check("sat_7fff_0001", {16'h0000, fft_out1024[1007 -: 16]}, 32'h00008000);

    // Return to IDLE, then core busy blocks a new load
    step();
    step();
    cs = 1'b1;
    step();
    cs = 1'b0;
    fft_processing = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("busy_load[%0d]", i), {31'd0, fft_load}, 32'd0);
    end

    // Round 3: random frame, asynchronous reset mid-load
    for (int k = 0; k < 64; k++) frame[k] = 16'($urandom);
    do_load(-1, 20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
